// File: rtl/capture_controller.sv
// Command decoder and capture sequencer for a logic-analyser front end: holds trigger/sampling
// config, runs the arm/trigger/post-trigger-delay capture flow and streams the 4-byte device ID.
module capture_controller (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_recieved,
    input  logic [7:0]  i_opcode,
    input  logic [31:0] i_command,
    input  logic        i_sample_valid,
    input  logic        i_trigger_hit,
    input  logic        i_tx_busy,
    output logic [31:0] o_trig_mask,
    output logic [31:0] o_trig_value,
    output logic [23:0] o_divider,
    output logic [15:0] o_read_count,
    output logic [15:0] o_delay_count,
    output logic        o_capture_run,
    output logic        o_capture_done,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArmed = 3'd1,
        StDelay = 3'd2,
        StDone  = 3'd3,
        StIdTx  = 3'd4
    } state_t;

    localparam logic [7:0] OpReset   = 8'h00;
    localparam logic [7:0] OpArm     = 8'h01;
    localparam logic [7:0] OpId      = 8'h02;
    localparam logic [7:0] OpDivider = 8'h80;
    localparam logic [7:0] OpCounts  = 8'h81;
    localparam logic [7:0] OpMask    = 8'hC0;
    localparam logic [7:0] OpValue   = 8'hC1;

    state_t      r_state;
    logic [31:0] r_trig_mask;
    logic [31:0] r_trig_value;
    logic [23:0] r_divider;
    logic [15:0] r_read_count;
    logic [15:0] r_delay_count;
    logic [15:0] r_delay_cnt;
    logic        r_capture_run;
    logic        r_capture_done;
    logic        r_tx_start;
    logic        r_tx_hold;
    logic [7:0]  r_tx_data;
    logic [2:0]  r_id_idx;

    logic        w_reset_cmd;
    logic [7:0]  w_id_byte;

    assign w_reset_cmd = i_cmd_recieved && (i_opcode == OpReset);

    always_comb begin
        w_id_byte = 8'h31;
        case (r_id_idx[1:0])
            2'd0:    w_id_byte = 8'h31;
            2'd1:    w_id_byte = 8'h41;
            2'd2:    w_id_byte = 8'h4C;
            default: w_id_byte = 8'h53;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= StIdle;
            r_trig_mask    <= 32'h0;
            r_trig_value   <= 32'h0;
            r_divider      <= 24'h0;
            r_read_count   <= 16'h0;
            r_delay_count  <= 16'h0;
            r_delay_cnt    <= 16'h0;
            r_capture_run  <= 1'b0;
            r_capture_done <= 1'b0;
            r_tx_start     <= 1'b0;
            r_tx_hold      <= 1'b0;
            r_tx_data      <= 8'h00;
            r_id_idx       <= 3'd0;
        end else begin
            r_capture_done <= 1'b0;
            r_tx_start     <= 1'b0;
            // Reset opcode beats every state transition, including a same-cycle trigger
            if (w_reset_cmd) begin
                r_state       <= StIdle;
                r_delay_cnt   <= 16'h0;
                r_capture_run <= 1'b0;
                r_tx_hold     <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (i_cmd_recieved) begin
                            case (i_opcode)
                                OpMask:    r_trig_mask  <= i_command;
                                OpValue:   r_trig_value <= i_command;
                                OpDivider: r_divider    <= i_command[23:0];
                                OpCounts: begin
                                    r_read_count  <= i_command[31:16];
                                    r_delay_count <= i_command[15:0];
                                end
                                OpArm: begin
                                    r_state       <= StArmed;
                                    r_capture_run <= 1'b1;
                                end
                                OpId: begin
                                    r_state   <= StIdTx;
                                    r_id_idx  <= 3'd0;
                                    r_tx_hold <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                    StArmed: begin
                        if (i_sample_valid && i_trigger_hit) begin
                            r_state     <= StDelay;
                            r_delay_cnt <= 16'h0;
                        end
                    end
                    StDelay: begin
                        // Equality is tested before incrementing, so the counter never wraps
                        if (r_delay_cnt == r_delay_count) begin
                            r_state        <= StDone;
                            r_capture_run  <= 1'b0;
                            r_capture_done <= 1'b1;
                        end else if (i_sample_valid) begin
                            r_delay_cnt <= r_delay_cnt + 16'd1;
                        end
                    end
                    StDone: begin
                        r_state <= StIdle;
                    end
                    StIdTx: begin
                        // Busy is not yet valid the cycle after a pulse; skip it
                        if (r_tx_start) begin
                            r_tx_hold <= 1'b1;
                        end else if (r_tx_hold) begin
                            r_tx_hold <= 1'b0;
                        end else if (!i_tx_busy) begin
                            if (r_id_idx == 3'd4) begin
                                r_state <= StIdle;
                            end else begin
                                r_tx_start <= 1'b1;
                                r_tx_data  <= w_id_byte;
                                r_id_idx   <= r_id_idx + 3'd1;
                            end
                        end
                    end
                    default: begin
                        r_state       <= StIdle;
                        r_capture_run <= 1'b0;
                        r_tx_hold     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_trig_mask    = r_trig_mask;
    assign o_trig_value   = r_trig_value;
    assign o_divider      = r_divider;
    assign o_read_count   = r_read_count;
    assign o_delay_count  = r_delay_count;
    assign o_capture_run  = r_capture_run;
    assign o_capture_done = r_capture_done;
    assign o_tx_start     = r_tx_start;
    assign o_tx_data      = r_tx_data;

endmodule

// File: tb/tb_capture_controller.sv
// Self-checking bench for capture_controller: config vector table, capture timing scoreboard,
// ID byte stream with a tx_busy model, and reset/abort sequences.
module tb_capture_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_recieved = 1'b0;
    logic [7:0]  opcode = 8'h00;
    logic [31:0] command = 32'h0;
    logic        sample_valid = 1'b0;
    logic        trigger_hit = 1'b0;
    logic        tx_busy = 1'b0;

    logic [31:0] trig_mask;
    logic [31:0] trig_value;
    logic [23:0] divider;
    logic [15:0] read_count;
    logic [15:0] delay_count;
    logic        capture_run;
    logic        capture_done;
    logic        tx_start;
    logic [7:0]  tx_data;

    capture_controller u_dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cmd_recieved (cmd_recieved),
        .i_opcode       (opcode),
        .i_command      (command),
        .i_sample_valid (sample_valid),
        .i_trigger_hit  (trigger_hit),
        .i_tx_busy      (tx_busy),
        .o_trig_mask    (trig_mask),
        .o_trig_value   (trig_value),
        .o_divider      (divider),
        .o_read_count   (read_count),
        .o_delay_count  (delay_count),
        .o_capture_run  (capture_run),
        .o_capture_done (capture_done),
        .o_tx_start     (tx_start),
        .o_tx_data      (tx_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [7:0]  op;
        logic [31:0] cmd;
        logic [31:0] mask;
        logic [31:0] value;
        logic [23:0] div;
        logic [15:0] rc;
        logic [15:0] dc;
    } cfg_vec_t;

    typedef struct {
        logic run;
        logic done;
    } cap_exp_t;

    int errors = 0;
    int checks = 0;
    int tx_pulses = 0;
    int busy_cnt = 0;
    logic [7:0] tx_q[$];
    cfg_vec_t   cfg_q[$];
    cap_exp_t   cap_q[$];
    cfg_vec_t   cfg_tab[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_trig_mask"},    trig_mask, 32'h0);
        check({tag, "_trig_value"},   trig_value, 32'h0);
        check({tag, "_divider"},      32'(divider), 32'h0);
        check({tag, "_read_count"},   32'(read_count), 32'h0);
        check({tag, "_delay_count"},  32'(delay_count), 32'h0);
        check({tag, "_capture_run"},  32'(capture_run), 32'h0);
        check({tag, "_capture_done"}, 32'(capture_done), 32'h0);
        check({tag, "_tx_start"},     32'(tx_start), 32'h0);
        check({tag, "_tx_data"},      32'(tx_data), 32'h0);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] cmd);
        opcode       = op;
        command      = cmd;
        cmd_recieved = 1'b1;
        @(negedge clk);
        cmd_recieved = 1'b0;
    endtask

    task automatic run_capture_queue(input string tag);
        cap_exp_t e;
        int k;
        k = 0;
        sample_valid = 1'b1;
        trigger_hit  = 1'b1;
        while (cap_q.size() > 0) begin
            @(negedge clk);
            trigger_hit = 1'b0;
            e = cap_q.pop_front();
            check($sformatf("%s_run_T%0d", tag, k + 1), 32'(capture_run), 32'(e.run));
            check($sformatf("%s_done_T%0d", tag, k + 1), 32'(capture_done), 32'(e.done));
            k++;
        end
        sample_valid = 1'b0;
    endtask

    // Transmit monitor and tx_busy model: busy for 10 cycles after each start pulse
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                tx_pulses++;
                check("tx_start_while_busy", 32'(tx_busy), 32'h0);
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx_start: got pulse with data 0x%0h, expected none",
                             tx_data);
                end else begin
                    check("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
                end
                busy_cnt = 10;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            tx_busy = (busy_cnt > 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        cfg_vec_t e;
        int start_pulses;

        cfg_tab[0] = '{1'b1, 8'hC0, 32'h0000_00FF, 32'hFF, 32'h0,  24'h0,      16'h0,    16'h0};
        cfg_tab[1] = '{1'b1, 8'hC1, 32'h0000_0012, 32'hFF, 32'h12, 24'h0,      16'h0,    16'h0};
        cfg_tab[2] = '{1'b1, 8'h80, 32'hAB12_3456, 32'hFF, 32'h12, 24'h123456, 16'h0,    16'h0};
        cfg_tab[3] = '{1'b1, 8'h81, 32'h0100_0004, 32'hFF, 32'h12, 24'h123456, 16'h0100, 16'h4};
        cfg_tab[4] = '{1'b1, 8'h55, 32'hFFFF_FFFF, 32'hFF, 32'h12, 24'h123456, 16'h0100, 16'h4};
        cfg_tab[5] = '{1'b0, 8'hC0, 32'h1234_5678, 32'hFF, 32'h12, 24'h123456, 16'h0100, 16'h4};

        repeat (2) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            opcode       = cfg_tab[i].op;
            command      = cfg_tab[i].cmd;
            cmd_recieved = cfg_tab[i].vld;
            cfg_q.push_back(cfg_tab[i]);
            @(negedge clk);
            cmd_recieved = 1'b0;
            e = cfg_q.pop_front();
            check($sformatf("cfg%0d_trig_mask", i), trig_mask, e.mask);
            check($sformatf("cfg%0d_trig_value", i), trig_value, e.value);
            check($sformatf("cfg%0d_divider", i), 32'(divider), 32'(e.div));
            check($sformatf("cfg%0d_read_count", i), 32'(read_count), 32'(e.rc));
            check($sformatf("cfg%0d_delay_count", i), 32'(delay_count), 32'(e.dc));
        end
        check("idle_run", 32'(capture_run), 32'h0);

        // delay_count=4, sample_valid every cycle
        send_cmd(8'h01, 32'h0);
        check("armed_run", 32'(capture_run), 32'h1);
        trigger_hit  = 1'b1;
        sample_valid = 1'b0;
        @(negedge clk);
        trigger_hit = 1'b0;
        check("unqualified_trigger_run", 32'(capture_run), 32'h1);
        check("unqualified_trigger_done", 32'(capture_done), 32'h0);
        for (int k = 0; k < 5; k++) cap_q.push_back('{1'b1, 1'b0});
        cap_q.push_back('{1'b0, 1'b1});
        cap_q.push_back('{1'b0, 1'b0});
        cap_q.push_back('{1'b0, 1'b0});
        run_capture_queue("dly4");

        // delay_count=0, config write ignored while armed
        send_cmd(8'h81, 32'h0100_0000);
        check("dc0_delay_count", 32'(delay_count), 32'h0);
        send_cmd(8'h01, 32'h0);
        send_cmd(8'hC0, 32'hDEAD_BEEF);
        check("armed_cfg_ignored", trig_mask, 32'hFF);
        cap_q.push_back('{1'b1, 1'b0});
        cap_q.push_back('{1'b0, 1'b1});
        cap_q.push_back('{1'b0, 1'b0});
        cap_q.push_back('{1'b0, 1'b0});
        run_capture_queue("dly0");

        // Full ID transfer
        tx_q.push_back(8'h31);
        tx_q.push_back(8'h41);
        tx_q.push_back(8'h4C);
        tx_q.push_back(8'h53);
        start_pulses = tx_pulses;
        send_cmd(8'h02, 32'h0);
        repeat (80) @(negedge clk);
        check("id_pulse_count", 32'(tx_pulses - start_pulses), 32'd4);
        check("id_queue_drained", 32'(tx_q.size()), 32'd0);
        send_cmd(8'hC1, 32'h0000_0077);
        check("id_back_to_idle", trig_value, 32'h77);

        // Reset opcode racing a trigger
        send_cmd(8'h01, 32'h0);
        check("abort_armed_run", 32'(capture_run), 32'h1);
        opcode       = 8'h00;
        command      = 32'h0;
        cmd_recieved = 1'b1;
        sample_valid = 1'b1;
        trigger_hit  = 1'b1;
        @(negedge clk);
        cmd_recieved = 1'b0;
        sample_valid = 1'b0;
        trigger_hit  = 1'b0;
        check("reset_wins_run", 32'(capture_run), 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("reset_wins_done_%0d", k), 32'(capture_done), 32'h0);
        end
        check("reset_op_keeps_mask", trig_mask, 32'hFF);

        // Hardware reset in the middle of an ID transfer
        tx_q.push_back(8'h31);
        start_pulses = tx_pulses;
        send_cmd(8'h02, 32'h0);
        for (int i = 0; i < 20 && tx_pulses == start_pulses; i++) @(negedge clk);
        check("mid_id_first_pulse", 32'(tx_pulses - start_pulses), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("mid_id_no_more_pulses", 32'(tx_pulses - start_pulses), 32'd1);
        check("mid_id_queue_drained", 32'(tx_q.size()), 32'd0);
        check("post_reset_done", 32'(capture_done), 32'h0);
        check("post_reset_run", 32'(capture_run), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
